// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: register-file address/data
// widths, the hard-wired zero register, and the queued-result entry layout.
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of pending multiply/divide results. Each slot carries a valid bit that
// a parallel address compare can clear, so stale results are dropped at pop time.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              cancel_en,
    input  logic [ADDR_W-1:0] cancel_addr,
    output wb_entry_t         head,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;

        // Cancel runs before the push so a same-cycle push keeps the valid bit it was given.
        if (cancel_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == cancel_addr) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (push) begin
            valid_d[wr_ptr_q] = push_entry.valid;
            addr_d[wr_ptr_q]  = push_entry.waddr;
            data_d[wr_ptr_q]  = push_entry.data;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        head.valid = valid_q[rd_ptr_q];
        head.waddr = addr_q[rd_ptr_q];
        head.data  = data_q[rd_ptr_q];
        empty      = (count_q == '0);
        full       = (count_q == (PTR_W+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload needs no reset: a slot is only read after a push has filled it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and mul/div results onto the single register-file write port.
// Optional starvation guard (counter + alu_stall) is enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_waddr,
    input  logic [DATA_W-1:0] md_data,
    output logic              wr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] din,
    output logic              alu_stall
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_params
        $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_MAX >= 1");
    end

    logic      alu_go, md_acc, md_nz, bypass;
    logic      q_push, q_pop, q_empty, q_full;
    wb_entry_t q_head, q_push_entry;

    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] din_q, din_d;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (q_push),
        .push_entry  (q_push_entry),
        .pop         (q_pop),
        .cancel_en   (alu_go),
        .cancel_addr (alu_waddr),
        .head        (q_head),
        .empty       (q_empty),
        .full        (q_full)
    );

    assign md_ready = !q_full;

    always_comb begin
        alu_go = alu_valid && (alu_waddr != REG_ZERO);
        md_acc = md_valid && !q_full;
        md_nz  = (md_waddr != REG_ZERO);
        q_pop  = !alu_go && !q_empty;
        bypass = !alu_go && q_empty && md_acc && md_nz;
        q_push = md_acc && md_nz && !bypass;

        // A same-cycle ALU write to the same register is newer, so the MD result is born stale.
        q_push_entry.valid = !(alu_go && (alu_waddr == md_waddr));
        q_push_entry.waddr = md_waddr;
        q_push_entry.data  = md_data;

        wr_d    = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        if (alu_go) begin
            wr_d    = 1'b1;
            waddr_d = alu_waddr;
            din_d   = alu_data;
        end else if (q_pop) begin
            if (q_head.valid) begin
                wr_d    = 1'b1;
                waddr_d = q_head.waddr;
                din_d   = q_head.data;
            end
        end else if (bypass) begin
            wr_d    = 1'b1;
            waddr_d = md_waddr;
            din_d   = md_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
        end
    end

    assign wr    = wr_q;
    assign waddr = waddr_q;
    assign din   = din_q;

`ifdef WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             alu_stall_q, alu_stall_d;

    // Counts cycles the ALU holds the port while results wait; any pop resets the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        alu_stall_d  = 1'b0;
        if (q_pop) begin
            starve_cnt_d = '0;
        end else if (alu_go && !q_empty) begin
            if (starve_cnt_q == CNT_W'(STARVE_MAX - 1)) begin
                starve_cnt_d = '0;
                alu_stall_d  = 1'b1;
            end else begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            alu_stall_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            alu_stall_q  <= alu_stall_d;
        end
    end

    assign alu_stall = alu_stall_q;
`else
    assign alu_stall = 1'b0;
`endif

endmodule
